// File: rtl/multi_channel_delay_line_pkg.sv
// Shared types and helpers for the multi-channel delay line.
// Holds the delay-field width rule and the load-time delay clamp.
package multi_channel_delay_line_pkg;

  typedef struct packed {
    logic        clamped;
    logic [31:0] value;
  } clamp_t;

  function automatic int delay_width(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  // A delay of zero stages is meaningless, so it rounds up to one.
  function automatic clamp_t clamp_delay(input logic [31:0] value, input logic [31:0] max_depth);
    clamp_t r;
    r.clamped = 1'b0;
    r.value   = value;
    if (value == 32'd0) begin
      r.value   = 32'd1;
      r.clamped = 1'b1;
    end else if (value > max_depth) begin
      r.value   = max_depth;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_lane.sv
// One lane of sample storage: a MAX_DEPTH-stage shift chain with a runtime tap.
module delay_lane #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 8,
  parameter int DW        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  input  logic [DW-1:0]    i_tap,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] mem [MAX_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < MAX_DEPTH; k++) mem[k] <= '0;
    end else if (i_shift) begin
      mem[0] <= i_data;
      for (int k = 1; k < MAX_DEPTH; k++) mem[k] <= mem[k-1];
    end
  end

  // Compare-based tap select keeps the index width independent of MAX_DEPTH.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (i_tap == DW'(k)) o_data = mem[k];
    end
  end

endmodule

// File: rtl/multi_channel_delay_line.sv
// Delays CHANNELS lanes by a programmable 1..MAX_DEPTH stages, with valid
// tracking, stall, flush and a primed indicator.
module multi_channel_delay_line
  import multi_channel_delay_line_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int MAX_DEPTH = 8,
  localparam int DW       = delay_width(MAX_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ce,
  input  logic                      i_flush,
  input  logic                      i_load,
  input  logic [DW-1:0]             i_delay,
  input  logic                      i_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic [CHANNELS*WIDTH-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_primed,
  output logic                      o_delay_err,
  output logic [DW-1:0]             o_delay
);

  logic [MAX_DEPTH-1:0] v;
  logic [DW-1:0]        delay_reg;
  logic [DW-1:0]        cnt;
  logic [DW-1:0]        tap;
  logic                 err;
  logic                 shift_en;
  clamp_t               load_res;

  assign shift_en = i_ce & ~i_load & ~i_flush;
  assign tap      = delay_reg - DW'(1);
  assign load_res = clamp_delay(32'(i_delay), 32'(MAX_DEPTH));

  // Load and flush both invalidate the valid chain and restart the fill count;
  // the data stages are left alone since their valid bits now mask them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v         <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      delay_reg <= DW'(MAX_DEPTH);
    end else if (i_load) begin
      v         <= '0;
      cnt       <= '0;
      delay_reg <= DW'(load_res.value);
      err       <= err | load_res.clamped;
    end else if (i_flush) begin
      v   <= '0;
      cnt <= '0;
    end else if (i_ce) begin
      v[0] <= i_valid;
      for (int k = 1; k < MAX_DEPTH; k++) v[k] <= v[k-1];
      if (cnt < delay_reg) cnt <= cnt + DW'(1);
    end
  end

  always_comb begin
    o_valid = 1'b0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (tap == DW'(k)) o_valid = v[k];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    delay_lane #(
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH),
      .DW        (DW)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_shift (shift_en),
      .i_data  (i_data[c*WIDTH +: WIDTH]),
      .i_tap   (tap),
      .o_data  (o_data[c*WIDTH +: WIDTH])
    );
  end

  assign o_primed    = (cnt == delay_reg);
  assign o_delay_err = err;
  assign o_delay     = delay_reg;

endmodule

// File: tb/tb_multi_channel_delay_line.sv
// Directed bench for multi_channel_delay_line: driven samples go into a
// scoreboard queue and pop out once the programmed number of shifts has elapsed.
module tb_multi_channel_delay_line;

  localparam int WIDTH     = 8;
  localparam int CHANNELS  = 4;
  localparam int MAX_DEPTH = 8;
  localparam int DW        = $clog2(MAX_DEPTH + 1);
  localparam int DATA_W    = CHANNELS * WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_ce, i_flush, i_load, i_valid;
  logic [DW-1:0]     i_delay;
  logic [DATA_W-1:0] i_data;
  logic [DATA_W-1:0] o_data;
  logic              o_valid, o_primed, o_delay_err;
  logic [DW-1:0]     o_delay;

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0]   sb_q[$];
  int                exp_delay;
  int                shifts;
  logic              exp_err;
  logic              exp_valid;
  logic [DATA_W-1:0] exp_data;
  logic              data_known;

  multi_channel_delay_line #(
    .WIDTH     (WIDTH),
    .CHANNELS  (CHANNELS),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ce        (i_ce),
    .i_flush     (i_flush),
    .i_load      (i_load),
    .i_delay     (i_delay),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_primed    (o_primed),
    .o_delay_err (o_delay_err),
    .o_delay     (o_delay)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pack_lanes(input logic [7:0] b);
    logic [7:0] l1, l2, l3;
    l1 = b + 8'h10;
    l2 = b + 8'h20;
    l3 = b + 8'h30;
    return {l3, l2, l1, b};
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue("o_valid", 32'(o_valid), 32'(exp_valid));
    if (data_known) checkValue("o_data", o_data, exp_data);
    checkValue("o_primed", 32'(o_primed), 32'(shifts == exp_delay));
    checkValue("o_delay", 32'(o_delay), 32'(exp_delay));
    checkValue("o_delay_err", 32'(o_delay_err), 32'(exp_err));
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_delay  = MAX_DEPTH;
    exp_err    = 1'b0;
    shifts     = 0;
    exp_valid  = 1'b0;
    exp_data   = '0;
    data_known = 1'b1;
  endtask

  // One clock of stimulus, then the scoreboard update and output check.
  task automatic applyStimulus(input logic ce, input logic flush, input logic load,
                               input logic [DW-1:0] dly, input logic valid,
                               input logic [DATA_W-1:0] data);
    logic [DATA_W:0] entry;
    @(negedge clk);
    i_ce    = ce;
    i_flush = flush;
    i_load  = load;
    i_delay = dly;
    i_valid = valid;
    i_data  = data;
    @(posedge clk);
    #1;
    if (load) begin
      if (dly == '0) begin
        exp_delay = 1;
        exp_err   = 1'b1;
      end else if (int'(dly) > MAX_DEPTH) begin
        exp_delay = MAX_DEPTH;
        exp_err   = 1'b1;
      end else begin
        exp_delay = int'(dly);
      end
      sb_q.delete();
      shifts     = 0;
      exp_valid  = 1'b0;
      data_known = 1'b0;
    end else if (flush) begin
      sb_q.delete();
      shifts    = 0;
      exp_valid = 1'b0;
    end else if (ce) begin
      sb_q.push_back({valid, data});
      if (shifts < exp_delay) shifts++;
      if (sb_q.size() == exp_delay) begin
        entry      = sb_q.pop_front();
        exp_valid  = entry[DATA_W];
        exp_data   = entry[DATA_W-1:0];
        data_known = 1'b1;
      end else begin
        exp_valid  = 1'b0;
        data_known = 1'b0;
      end
    end
    checkOutput();
  endtask

  task automatic shift(input logic valid, input logic [7:0] b);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, valid, pack_lanes(b));
  endtask

  task automatic load(input logic [DW-1:0] dly);
    applyStimulus(1'b1, 1'b0, 1'b1, dly, 1'b1, pack_lanes(8'hFF));
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    i_ce    = 1'b0;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_load  = 1'b0;
    rst     = 1'b0;
    #1;
    model_reset();
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    i_ce    = 1'b0;
    i_flush = 1'b0;
    i_load  = 1'b0;
    i_delay = '0;
    i_valid = 1'b0;
    i_data  = '0;
    #12;
    model_reset();
    checkOutput();
    rst = 1'b1;

    for (int i = 1; i <= 12; i++) shift(1'b1, 8'(i));

    load(DW'(3));
    for (int i = 0; i < 8; i++) shift(1'b1, 8'(8'hA0 + i));

    load(DW'(0));
    shift(1'b1, 8'hB0);
    shift(1'b1, 8'hB1);
    load(DW'(12));
    for (int i = 0; i < 3; i++) shift(1'b1, 8'(8'hB2 + i));

    // Valid pattern with gaps and a five-cycle stall in the middle.
    load(DW'(4));
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        for (int s = 0; s < 5; s++)
          applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, pack_lanes(8'h55));
      end
      shift((i % 3) != 1, 8'(8'hC0 + i));
    end

    load(DW'(2));
    for (int i = 0; i < 6; i++) shift(1'b1, 8'(8'hD0 + i));
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, pack_lanes(8'hEE));
    for (int i = 0; i < 5; i++) shift(1'b1, 8'(8'hD8 + i));

    for (int i = 0; i < 3; i++) shift(1'b1, 8'(8'hE0 + i));
    async_reset();
    for (int i = 0; i < 3; i++) shift(1'b1, 8'(8'hF0 + i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
